// File: rtl/seg7_fmt_pkg.sv
// Shared types and constants for the 7-segment display formatter.
// Holds the FSM states, mode encodings, decimal range limit and the "E" digit code.
package seg7_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_t;

  localparam logic        MODE_HEX   = 1'b0;
  localparam logic        MODE_DEC   = 1'b1;
  localparam logic [31:0] DEC_MAX    = 32'd99_999_999;
  localparam logic [7:0]  DIG_E      = 8'h0E;
  localparam int          NUM_DIGITS = 8;

  // Double-dabble correction applied to one BCD nibble before each shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per cycle.
// Inputs must be <= 99_999_999 so that the result fits in eight BCD nibbles.
module bin2bcd_seq
  import seg7_fmt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  output logic [31:0] bcd,
  output logic        valid
);

  logic [31:0] bcd_reg;
  logic [31:0] bin_reg;
  logic [4:0]  cnt_reg;
  logic        run_reg;
  logic [31:0] bcd_adj;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = add3(bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (start) begin
      bcd_reg <= '0;
      bin_reg <= value;
      cnt_reg <= 5'd31;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
      if (cnt_reg == 5'd0) begin
        run_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - 5'd1;
      end
    end
  end

  // valid marks the cycle whose closing edge performs the 32nd shift, so
  // bcd holds the finished result during the following cycle.
  assign valid = run_reg && (cnt_reg == 5'd0) && !start;
  assign bcd   = bcd_reg;

endmodule

// File: rtl/seg7_formatter.sv
// Formats a 32-bit MMIO value into eight per-digit byte codes (hex or decimal),
// with optional leading-zero blanking; the display only changes on done.
module seg7_formatter
  import seg7_fmt_pkg::*;
#(
  parameter logic [7:0] BLANK_CODE = 8'hFF,
  parameter bit         RESET_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        mode,
  input  logic        blank_lz,
  output logic [31:0] seg_lo,
  output logic [31:0] seg_hi,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam logic [63:0] RESET_DISP = RESET_ZERO ? 64'h0 : {NUM_DIGITS{BLANK_CODE}};

  state_t      state_reg, state_next;
  logic [31:0] val_reg;
  logic        mode_reg;
  logic        blank_reg;
  logic        ovf_req_reg;
  logic [63:0] seg_reg;
  logic        ovf_reg;
  logic        done_reg;

  logic        req_ovf;
  logic        start_bcd;
  logic        commit;
  logic        bcd_valid;
  logic [31:0] bcd;
  logic [63:0] raw_digits;
  logic [63:0] fmt_digits;
  logic [NUM_DIGITS-1:0] nz;

  assign req_ovf = (mode == MODE_DEC) && (wr_data > DEC_MAX);

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_bcd),
    .value (wr_data),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

  // State register plus request latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      val_reg     <= '0;
      mode_reg    <= MODE_HEX;
      blank_reg   <= 1'b0;
      ovf_req_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (wr_en) begin
        val_reg     <= wr_data;
        mode_reg    <= mode;
        blank_reg   <= blank_lz;
        ovf_req_reg <= req_ovf;
      end
    end
  end

  // Next-state logic: a new request always wins over whatever is in flight.
  always_comb begin
    state_next = state_reg;
    if (wr_en) begin
      state_next = (mode == MODE_HEX || req_ovf) ? FORMAT : SHIFT;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        SHIFT:   state_next = bcd_valid ? FORMAT : SHIFT;
        FORMAT:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    start_bcd = wr_en && (mode == MODE_DEC) && !req_ovf;
    commit    = (state_reg == FORMAT) && !wr_en;
    busy      = (state_reg != IDLE);
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign raw_digits[gi*8 +: 8] = ovf_req_reg ? DIG_E :
        {4'h0, (mode_reg == MODE_HEX) ? val_reg[gi*4 +: 4] : bcd[gi*4 +: 4]};
      assign nz[gi] = (raw_digits[gi*8 +: 8] != 8'h00);
      if (gi == 0) begin : g_lsd
        assign fmt_digits[gi*8 +: 8] = raw_digits[gi*8 +: 8];
      end else begin : g_upper
        // Blank when this digit and everything above it are zero.
        assign fmt_digits[gi*8 +: 8] =
          (blank_reg && !ovf_req_reg && !(|nz[NUM_DIGITS-1:gi])) ? BLANK_CODE : raw_digits[gi*8 +: 8];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg  <= RESET_DISP;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= commit;
      if (commit) begin
        seg_reg <= fmt_digits;
        ovf_reg <= ovf_req_reg;
      end
    end
  end

  assign seg_lo   = seg_reg[31:0];
  assign seg_hi   = seg_reg[63:32];
  assign done     = done_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_seg7_formatter.sv
// Directed self-checking bench for seg7_formatter: table of single requests
// plus hand-written abort, FORMAT-collision and mid-conversion reset sequences.
module tb_seg7_formatter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [31:0] seg_lo, seg_hi;
  logic        busy, done, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_formatter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .mode     (mode),
    .blank_lz (blank_lz),
    .seg_lo   (seg_lo),
    .seg_hi   (seg_hi),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        m;
    logic        b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns 1 time unit after the accepting edge E0.
  task automatic start_req(input logic [31:0] d, input logic m, input logic b);
    wr_data  = d;
    mode     = m;
    blank_lz = b;
    wr_en    = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int lat, bc, nd;
    logic [63:0] held;

    vecs[0]  = '{32'h1234ABCD, 1'b0, 1'b0, 32'h0A0B0C0D, 32'h01020304, 1'b0, 1};
    vecs[1]  = '{32'd12345,    1'b1, 1'b1, 32'h02030405, 32'hFFFFFF01, 1'b0, 33};
    vecs[2]  = '{32'd99999999, 1'b1, 1'b0, 32'h09090909, 32'h09090909, 1'b0, 33};
    vecs[3]  = '{32'd100000000,1'b1, 1'b0, 32'h0E0E0E0E, 32'h0E0E0E0E, 1'b1, 1};
    vecs[4]  = '{32'd100000000,1'b1, 1'b1, 32'h0E0E0E0E, 32'h0E0E0E0E, 1'b1, 1};
    vecs[5]  = '{32'd0,        1'b1, 1'b1, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b0, 33};
    vecs[6]  = '{32'd0,        1'b0, 1'b1, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b0, 1};
    vecs[7]  = '{32'h00000F00, 1'b0, 1'b1, 32'hFF0F0000, 32'hFFFFFFFF, 1'b0, 1};
    vecs[8]  = '{32'd12345,    1'b1, 1'b0, 32'h02030405, 32'h00000001, 1'b0, 33};
    vecs[9]  = '{32'hFFFFFFFF, 1'b1, 1'b0, 32'h0E0E0E0E, 32'h0E0E0E0E, 1'b1, 1};
    vecs[10] = '{32'd1000,     1'b1, 1'b1, 32'h01000000, 32'hFFFFFFFF, 1'b0, 33};

    repeat (3) @(posedge clk);
    #1;
    check("reset_seg", {seg_hi, seg_lo}, {32'hFFFFFFFF, 32'hFFFFFFFF});
    check("reset_flags", {61'd0, busy, done, overflow}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      start_req(vecs[i].data, vecs[i].m, vecs[i].b);
      wait_done(lat, bc);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat);
      check($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
      check($sformatf("v%0d_seg_lo", i), seg_lo, vecs[i].lo);
      check($sformatf("v%0d_seg_hi", i), seg_hi, vecs[i].hi);
      check($sformatf("v%0d_overflow", i), overflow, vecs[i].ovf);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_width", i), done, 1'b0);
      $display("[TB] vec %0d data=%h mode=%0d blank=%0d -> lo=%h hi=%h ovf=%0d lat=%0d",
               i, vecs[i].data, vecs[i].m, vecs[i].b, seg_lo, seg_hi, overflow, lat);
    end

    // Abort: a hex request 10 cycles into a decimal conversion replaces it.
    held = {seg_hi, seg_lo};
    start_req(32'd12345, 1'b1, 1'b0);
    count_dones(9, nd);
    start_req(32'h7, 1'b0, 1'b1);
    check("abort_no_done", nd + int'(done), 0);
    check("abort_display_held", {seg_hi, seg_lo}, held);
    @(posedge clk);
    #1;
    check("abort_done", done, 1'b1);
    check("abort_seg", {seg_hi, seg_lo}, {32'hFFFFFFFF, 32'hFFFFFF07});
    count_dones(40, nd);
    check("abort_single_done", nd, 0);
    $display("[TB] abort/restart -> lo=%h hi=%h", seg_lo, seg_hi);

    // Request arriving in the FORMAT cycle discards that result.
    wr_data = 32'h5; mode = 1'b0; blank_lz = 1'b1; wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_data = 32'h6;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("collide_no_done", done, 1'b0);
    @(posedge clk);
    #1;
    check("collide_done", done, 1'b1);
    check("collide_seg", {seg_hi, seg_lo}, {32'hFFFFFFFF, 32'hFFFFFF06});
    $display("[TB] format collision -> lo=%h", seg_lo);

    // Reset in the middle of a decimal conversion.
    start_req(32'hFFFFFFFF, 1'b1, 1'b0);
    wait_done(lat, bc);
    check("pre_reset_overflow", overflow, 1'b1);
    start_req(32'd12345, 1'b1, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_seg", {seg_hi, seg_lo}, {32'hFFFFFFFF, 32'hFFFFFFFF});
    check("rst_flags", {61'd0, busy, done, overflow}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_dones(40, nd);
    check("rst_no_done", nd, 0);
    check("rst_idle", {busy, seg_lo}, {1'b0, 32'hFFFFFFFF});
    $display("[TB] reset mid-shift -> busy=%0d lo=%h", busy, seg_lo);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_formatter.md
Name: seg7_formatter

Overview:
- Converts a 32-bit value written by the CPU's MMIO path into eight per-digit byte codes for the downstream 7-segment scan driver.
- Two display modes:
  - Hex: immediate.
  - Unsigned decimal: sequential double-dabble, one bit per cycle.
- Optional leading-zero blanking.
- Holds the last completed display, so the scan driver never sees partial results.

Parameters:
- BLANK_CODE, 8'hFF, byte emitted for a blanked digit; must not equal any digit code.
- RESET_ZERO, 0, 1 = reset display shows all 8'h00 ("0"); 0 = reset display all BLANK_CODE.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  one-cycle request to display wr_data
- wr_data  input  32  value to display
- mode  input  1  0 = hex, 1 = unsigned decimal; sampled with wr_en
- blank_lz  input  1  1 = blank leading zero digits; sampled with wr_en
- seg_lo  output  32  digits 0..3; digit 0 (least significant) in [7:0]
- seg_hi  output  32  digits 4..7; digit 4 in [7:0]
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse when seg_lo/seg_hi update
- overflow  output  1  last decimal request exceeded 99_999_999; held until next completion

Behaviour:
- Clock and reset: clk rising edge; rst_n asynchronous active-low.
- Digit code: digit value v (0..15) is emitted as byte v. Blanked digits are emitted as BLANK_CODE.
- Reset state:
  - State IDLE.
  - seg_lo/seg_hi all BLANK_CODE, or all 8'h00 if RESET_ZERO.
  - busy, done, overflow all 0.
- States: IDLE, SHIFT, FORMAT.
- Accept (edge E0): wr_en sampled high in any state.
  - Latch wr_data, mode, blank_lz.
  - Hex, or decimal with wr_data > 99_999_999: go to FORMAT.
  - Decimal in range: go to SHIFT, with bcd = 0 and bit counter = 31.
- SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, value} left by 1.
  - After 32 shifts (edges E1..E32) go to FORMAT.
- FORMAT (one cycle):
  - Build 8 digits:
    - Hex: the nibbles of the value.
    - Decimal: the BCD nibbles.
    - Overflow: all 8'h0E ("E").
  - If blank_lz: replace every digit above the most-significant nonzero digit with BLANK_CODE. Digit 0 is never blanked, so 0 shows "0". Blanking is not applied on overflow.
  - At the next edge: register seg_lo/seg_hi, update overflow, pulse done, return to IDLE.
- Latency from E0:
  - Hex or overflow: outputs and done at E1.
  - Decimal: outputs and done at E33.
- busy: high from E0 until the edge where done is registered. busy is 0 in the cycle done is 1.
- wr_en while busy: the current conversion is aborted and restarted with the new request (latest wins). No done is produced for the aborted request, and the display keeps its previous contents.
- wr_en in the same cycle as FORMAT: the FORMAT result is discarded and the new request is accepted.
- Reset mid-operation: everything returns to reset values immediately; no done pulse.
- Outputs change only at done edges or on reset.

Decomposition:
- Package seg7_fmt_pkg:
  - state enum {IDLE, SHIFT, FORMAT}
  - mode constants MODE_HEX = 0, MODE_DEC = 1
  - DEC_MAX = 32'd99_999_999
  - DIG_E = 8'h0E
  - digit count 8
- Sub-module bin2bcd_seq:
  - Interface: start, value[31:0], bcd[31:0], valid.
  - Contains the shift/add-3 engine and the 5-bit bit counter.
  - start restarts the engine from any state.
  - valid pulses after 32 shifts.
- Top level holds the FSM, the blanking logic and the display registers.

Test Plan:
- Hex, no blanking: wr 0x1234ABCD, mode 0, blank_lz 0 -> at E1 seg_hi=0x01020304, seg_lo=0x0A0B0C0D, done pulses 1 cycle, busy high exactly 1 cycle.
- Decimal with blanking: wr 12345, mode 1, blank_lz 1 -> busy for 33 cycles; at E33 seg_lo=0x02030405, seg_hi=0xFFFFFF01, overflow 0, single done.
- Decimal boundary: wr 99_999_999 -> all digits 0x09, overflow 0, at E33. Then wr 100_000_000 -> at E1 all bytes 0x0E, overflow 1.
- Zero with blanking:
  - Mode 1, wr 0, blank_lz 1 -> seg_lo=0xFFFFFF00, seg_hi=0xFFFFFFFF.
  - Mode 0, same value and blank_lz -> identical output.
- Abort/restart: decimal wr 12345, then 10 cycles later hex wr 0x7 with blank_lz 1 -> no done for 12345; display unchanged until 1 cycle later; then seg_lo=0xFFFFFF07; exactly one done.
- Reset mid-SHIFT: rst_n low at cycle 15 of a decimal conversion -> outputs all 0xFF, busy 0, no done after release until a new wr_en.
